// File: rtl/ga_crossover_sp.sv
// Single-point crossover stage: accepts a parent pair, reduces the random cut modulo the
// chromosome length, emits two masked children. Optional macro GA_CROSSOVER_PROB_EN adds a crossover-probability bypass.
module ga_crossover_sp #(
  parameter int CHROM_MAX_W = 32,
  parameter int CHROM_LEN_W = $clog2(CHROM_MAX_W + 1),
  parameter int CUT_W       = $clog2(CHROM_MAX_W)
) (
  input  logic                   clk,
  input  logic                   sw_rst,
  input  logic [CHROM_LEN_W-1:0] cnfg_chrom_len,
  input  logic [CUT_W-1:0]       rand_data,
`ifdef GA_CROSSOVER_PROB_EN
  input  logic [7:0]             cnfg_xover_prob,
  input  logic [7:0]             rand_prob,
`endif
  input  logic                   parents_valid,
  input  logic [CHROM_MAX_W-1:0] parent1,
  input  logic [CHROM_MAX_W-1:0] parent2,
  output logic                   parents_ack,
  output logic                   children_valid,
  output logic [CHROM_MAX_W-1:0] child1,
  output logic [CHROM_MAX_W-1:0] child2,
  input  logic                   children_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC_CUT = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CHROM_MAX_W-1:0] p1_q, p2_q;
  logic [CHROM_LEN_W-1:0] len_q;
  logic [CUT_W-1:0]       cut_q;
  logic                   parents_ack_q;
  logic                   children_valid_q;
  logic [CHROM_MAX_W-1:0] child1_q, child2_q;

  logic [CHROM_LEN_W-1:0] len_d;
  logic [CUT_W-1:0]       cut_d;
  logic [CUT_W-1:0]       cut_sub_d;
  logic [CUT_W-1:0]       eff_cut;
  logic [CHROM_MAX_W-1:0] len_mask, cut_mask;
  logic [CHROM_MAX_W-1:0] child1_d, child2_d;
  logic                   cut_done;
  logic                   bypass;

`ifdef GA_CROSSOVER_PROB_EN
  logic [7:0] xprob_q, rprob_q;

  // A zero probability can never satisfy rand < prob, so it always bypasses.
  always_comb begin
    bypass = !(rprob_q < xprob_q);
  end
`else
  always_comb begin
    bypass = 1'b0;
  end
`endif

  always_comb begin
    len_d = cnfg_chrom_len;
    if (cnfg_chrom_len > CHROM_LEN_W'(CHROM_MAX_W)) begin
      len_d = CHROM_LEN_W'(CHROM_MAX_W);
    end
    cut_d = rand_data;
    if (len_d < CHROM_LEN_W'(2)) begin
      cut_d = '0;
    end
  end

  // Lengths below 2 leave no meaningful cut; they also stop a zero-length divide from looping.
  always_comb begin
    cut_done  = bypass || (int'(cut_q) < int'(len_q)) || (len_q < CHROM_LEN_W'(2));
    cut_sub_d = cut_q - CUT_W'(len_q);
    eff_cut   = bypass ? '0 : cut_q;
  end

  always_comb begin
    len_mask = '0;
    cut_mask = '0;
    for (int i = 0; i < CHROM_MAX_W; i++) begin
      len_mask[i] = (i < int'(len_q));
      cut_mask[i] = (i < int'(eff_cut));
    end
    child1_d = ((p2_q & cut_mask) | (p1_q & ~cut_mask)) & len_mask;
    child2_d = ((p1_q & cut_mask) | (p2_q & ~cut_mask)) & len_mask;
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q          <= IDLE;
      p1_q             <= '0;
      p2_q             <= '0;
      len_q            <= '0;
      cut_q            <= '0;
      parents_ack_q    <= 1'b0;
      children_valid_q <= 1'b0;
      child1_q         <= '0;
      child2_q         <= '0;
`ifdef GA_CROSSOVER_PROB_EN
      xprob_q          <= '0;
      rprob_q          <= '0;
`endif
    end else begin
      parents_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (parents_valid) begin
            p1_q          <= parent1;
            p2_q          <= parent2;
            len_q         <= len_d;
            cut_q         <= cut_d;
`ifdef GA_CROSSOVER_PROB_EN
            xprob_q       <= cnfg_xover_prob;
            rprob_q       <= rand_prob;
`endif
            parents_ack_q <= 1'b1;
            state_q       <= CALC_CUT;
          end
        end
        CALC_CUT: begin
          if (!cut_done) begin
            cut_q <= cut_sub_d;
          end else begin
            child1_q         <= child1_d;
            child2_q         <= child2_d;
            children_valid_q <= 1'b1;
            state_q          <= SEND;
          end
        end
        SEND: begin
          if (children_ack) begin
            children_valid_q <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign parents_ack    = parents_ack_q;
  assign children_valid = children_valid_q;
  assign child1         = child1_q;
  assign child2         = child2_q;

endmodule

// File: tb/tb_ga_crossover_sp.sv
// Scoreboard bench for ga_crossover_sp: directed pairs push expected children, a monitor pops on children_valid.
module tb_ga_crossover_sp;

  logic        clk = 1'b0;
  logic        sw_rst;
  logic [5:0]  cnfg_chrom_len;
  logic [4:0]  rand_data;
  logic        parents_valid;
  logic [31:0] parent1, parent2;
  logic        parents_ack, children_valid;
  logic [31:0] child1, child2;
  logic        children_ack;
`ifdef GA_CROSSOVER_PROB_EN
  logic [7:0]  cnfg_xover_prob, rand_prob;
`endif

  always #5 clk = ~clk;

  ga_crossover_sp dut (
    .clk            (clk),
    .sw_rst         (sw_rst),
    .cnfg_chrom_len (cnfg_chrom_len),
    .rand_data      (rand_data),
`ifdef GA_CROSSOVER_PROB_EN
    .cnfg_xover_prob(cnfg_xover_prob),
    .rand_prob      (rand_prob),
`endif
    .parents_valid  (parents_valid),
    .parent1        (parent1),
    .parent2        (parent2),
    .parents_ack    (parents_ack),
    .children_valid (children_valid),
    .child1         (child1),
    .child2         (child2),
    .children_ack   (children_ack)
  );

  typedef struct {
    logic [31:0] c1;
    logic [31:0] c2;
    int          k;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency is measured from the parents_ack cycle to the children_valid rise.
  int          cyc = 0;
  int          ack_cyc = 0;
  int          ack_count = 0;
  logic        prev_v = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] h1, h2;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (parents_ack === 1'b1) begin
      check("ack_one_cycle", {63'd0, prev_ack}, 64'd0);
      ack_cyc = cyc;
      ack_count++;
    end
    if (children_valid === 1'b1 && prev_v !== 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_children: got child1=0x%0h child2=0x%0h expected no output", child1, child2);
      end else begin
        e = q.pop_front();
        check({e.name, "_child1"}, {32'd0, child1}, {32'd0, e.c1});
        check({e.name, "_child2"}, {32'd0, child2}, {32'd0, e.c2});
        check({e.name, "_latency"}, 64'(cyc - ack_cyc), 64'(1 + e.k));
      end
      h1 = child1;
      h2 = child2;
    end else if (children_valid === 1'b1) begin
      check("hold_child1", {32'd0, child1}, {32'd0, h1});
      check("hold_child2", {32'd0, child2}, {32'd0, h2});
    end
    prev_v   = children_valid;
    prev_ack = parents_ack;
  end

  task automatic send_pair(input logic [5:0] len, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input int budget, output int waited);
    @(negedge clk);
    cnfg_chrom_len = len;
    parent1        = a;
    parent2        = b;
    rand_data      = r;
    parents_valid  = 1'b1;
    n_sent++;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (parents_ack !== 1'b1 && waited < budget);
    if (parents_ack !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got no parents_ack after %0d cycles expected ack", waited);
    end
    parents_valid = 1'b0;
    // Scramble sampled-at-acceptance inputs to show they no longer matter.
    cnfg_chrom_len = 6'($urandom);
    rand_data      = 5'($urandom);
    parent1        = $urandom;
    parent2        = $urandom;
`ifdef GA_CROSSOVER_PROB_EN
    cnfg_xover_prob = 8'($urandom);
    rand_prob       = 8'($urandom);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pair(input string name, input logic [5:0] len, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input logic [31:0] c1, input logic [31:0] c2, input int k);
    int w;
    exp_t x;
    x.c1 = c1; x.c2 = c2; x.k = k; x.name = name;
    q.push_back(x);
    send_pair(len, a, b, r, 20, w);
    check({name, "_ack_latency"}, 64'(w), 64'd1);
    drain();
  endtask

  initial begin
    int w;
    exp_t x;
    sw_rst         = 1'b1;
    parents_valid  = 1'b0;
    parent1        = '0;
    parent2        = '0;
    cnfg_chrom_len = '0;
    rand_data      = '0;
    children_ack   = 1'b1;
`ifdef GA_CROSSOVER_PROB_EN
    cnfg_xover_prob = 8'hFF;
    rand_prob       = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("rst_parents_ack", {63'd0, parents_ack}, 64'd0);
    check("rst_children_valid", {63'd0, children_valid}, 64'd0);
    check("rst_child1", {32'd0, child1}, 64'd0);
    check("rst_child2", {32'd0, child2}, 64'd0);
    sw_rst = 1'b0;

    run_pair("len8_cut3",  6'd8,  32'hFF,       32'h00,       5'd3,  32'hF8,       32'h07,       0);
    run_pair("len10_r27",  6'd10, 32'h3FF,      32'h000,      5'd27, 32'h380,      32'h07F,      2);
    run_pair("len4_cut0",  6'd4,  32'hFFFFFFFF, 32'h0000000A, 5'd0,  32'h0000000F, 32'h0000000A, 0);
    run_pair("len40_clamp",6'd40, 32'hFFFFFFFF, 32'h00000000, 5'd5,  32'hFFFFFFE0, 32'h0000001F, 0);
    run_pair("len1",       6'd1,  32'hFFFFFFFF, 32'h00000000, 5'd7,  32'h00000001, 32'h00000000, 0);
    run_pair("len0",       6'd0,  32'hFFFFFFFF, 32'h12345678, 5'd9,  32'h00000000, 32'h00000000, 0);
    run_pair("len3_r31",   6'd3,  32'h5,        32'h2,        5'd31, 32'h4,        32'h3,        10);
    run_pair("len2_r31",   6'd2,  32'h3,        32'h0,        5'd31, 32'h2,        32'h1,        15);

    // Backpressure: hold children_ack low while a second pair waits upstream.
    children_ack = 1'b0;
    x.c1 = 32'hF8; x.c2 = 32'h07; x.k = 0; x.name = "bp_first";
    q.push_back(x);
    x.c1 = 32'h380; x.c2 = 32'h07F; x.k = 2; x.name = "bp_second";
    q.push_back(x);
    send_pair(6'd8, 32'hFF, 32'h00, 5'd3, 20, w);
    check("bp_first_ack_latency", 64'(w), 64'd1);
    fork
      begin
        int w2;
        send_pair(6'd10, 32'h3FF, 32'h000, 5'd27, 60, w2);
        n_cmp++;
        if (w2 <= 5) begin
          n_fail++;
          $display("FAIL bp_second_ack_wait: got %0d cycles expected more than 5", w2);
        end
      end
      begin
        int n = 0;
        while (children_valid !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        children_ack = 1'b1;
      end
    join
    drain();

    // Reset while the cut is still being reduced: the pair is discarded.
    send_pair(6'd10, 32'h3FF, 32'h000, 5'd31, 20, w);
    @(negedge clk);
    sw_rst = 1'b1;
    @(negedge clk);
    check("midrst_parents_ack", {63'd0, parents_ack}, 64'd0);
    check("midrst_children_valid", {63'd0, children_valid}, 64'd0);
    check("midrst_child1", {32'd0, child1}, 64'd0);
    check("midrst_child2", {32'd0, child2}, 64'd0);
    sw_rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_children", {63'd0, children_valid}, 64'd0);
    run_pair("after_rst",  6'd8,  32'hFF,       32'h00,       5'd3,  32'hF8,       32'h07,       0);

`ifdef GA_CROSSOVER_PROB_EN
    cnfg_xover_prob = 8'h80;
    rand_prob       = 8'h90;
    run_pair("prob_bypass", 6'd8,  32'hFF,  32'h00,  5'd3,  32'hFF,  32'h00,  0);
    cnfg_xover_prob = 8'h80;
    rand_prob       = 8'h10;
    run_pair("prob_xover",  6'd8,  32'hFF,  32'h00,  5'd3,  32'hF8,  32'h07,  0);
    cnfg_xover_prob = 8'h00;
    rand_prob       = 8'h00;
    run_pair("prob_zero",   6'd10, 32'h3FF, 32'h000, 5'd27, 32'h3FF, 32'h000, 0);
`endif

    check("ack_count", 64'(ack_count), 64'(n_sent));
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
